// File: rtl/sg_pkg.sv
// Shared constants and types for the signal-generator write scheduler.
package sg_pkg;

  localparam int VOL_W  = 4;
  localparam int DATA_W = 5;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_PER_A = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_PER_B = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_VOL_A = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_VOL_B = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_VOL_N = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_EN    = 3'd5;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, STEP} envState_t;

endpackage

// File: rtl/sg_env_channel.sv
// One decay-envelope engine: ramps a volume register from PEAK down to 0,
// one write request per TICK_DIV-cycle step.
module sg_env_channel
  import sg_pkg::*;
#(
  parameter int                TICK_DIV = 4096,
  parameter int                TICK_W   = 12,
  parameter int                PEAK     = 15,
  parameter logic [ADDR_W-1:0] VOL_ADDR = ADDR_VOL_A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              envEn,
  input  logic              grant,
  input  logic              hostGrant,
  input  logic [ADDR_W-1:0] hostAddr,
  output logic              req,
  output logic [ADDR_W-1:0] reqAddr,
  output logic [DATA_W-1:0] reqData,
  output logic              busy
);

  envState_t         state, stateNxt;
  logic [VOL_W-1:0]  level, levelNxt;
  logic [TICK_W-1:0] tick, tickNxt;
  logic              abort;

  // A host write landing on our volume register wins, and the envelope stops.
  assign abort   = hostGrant && (hostAddr == VOL_ADDR);
  assign req     = (state == LOAD) || (state == STEP);
  assign reqAddr = VOL_ADDR;
  assign reqData = {1'b0, level};
  assign busy    = (state != IDLE);

  always_comb begin
    stateNxt = state;
    levelNxt = level;
    tickNxt  = tick;
    case (state)
      IDLE: ;
      LOAD: if (grant) begin
        stateNxt = WAIT;
        tickNxt  = '0;
      end
      WAIT: if (tick == TICK_W'(TICK_DIV - 1)) begin
        stateNxt = STEP;
        levelNxt = level - VOL_W'(1);
      end else begin
        tickNxt = tick + TICK_W'(1);
      end
      STEP: if (grant) begin
        stateNxt = (level != '0) ? WAIT : IDLE;
        tickNxt  = '0;
      end
      default: stateNxt = IDLE;
    endcase
    // A write granted this cycle still goes out; anything ungranted is dropped.
    if (!envEn || abort) stateNxt = IDLE;
    if (trig && envEn) begin
      stateNxt = LOAD;
      levelNxt = VOL_W'(PEAK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      level <= '0;
      tick  <= '0;
    end else begin
      state <= stateNxt;
      level <= levelNxt;
      tick  <= tickNxt;
    end
  end

endmodule

// File: rtl/sg_write_scheduler.sv
// Arbitrates the signal generator's register-write bus between a buffered
// host port and two envelope engines; one registered write per cycle.
module sg_write_scheduler
  import sg_pkg::*;
#(
  parameter int TICK_DIV = 4096,
  parameter int TICK_W   = 12,
  parameter int PEAK     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic [1:0]        trig,
  input  logic [1:0]        env_en,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        env_busy
);

  logic              holdFull, holdFullNxt;
  logic [ADDR_W-1:0] holdAddr;
  logic [DATA_W-1:0] holdData;
  logic              lastHost;
  logic              rrLast;
  logic              hostAccept, hostGrant, anyEnv, envPick;
  logic [1:0]        envReq, envGrant;
  logic [ADDR_W-1:0] envAddr [2];
  logic [DATA_W-1:0] envData [2];

  for (genvar ch = 0; ch < 2; ch++) begin : gChan
    sg_env_channel #(
      .TICK_DIV (TICK_DIV),
      .TICK_W   (TICK_W),
      .PEAK     (PEAK),
      .VOL_ADDR ((ch == 0) ? ADDR_VOL_A : ADDR_VOL_B)
    ) uChan (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig      (trig[ch]),
      .envEn     (env_en[ch]),
      .grant     (envGrant[ch]),
      .hostGrant (hostGrant),
      .hostAddr  (holdAddr),
      .req       (envReq[ch]),
      .reqAddr   (envAddr[ch]),
      .reqData   (envData[ch]),
      .busy      (env_busy[ch])
    );
  end

  // Host holds priority unless it was granted last time and an envelope waits.
  always_comb begin
    hostAccept  = host_valid && host_ready;
    anyEnv      = |envReq;
    envPick     = (&envReq) ? ~rrLast : envReq[1];
    hostGrant   = holdFull && !(lastHost && anyEnv);
    envGrant    = '0;
    if (!hostGrant && anyEnv) envGrant[envPick] = 1'b1;
    holdFullNxt = hostAccept || (holdFull && !hostGrant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_ready <= 1'b0;
      holdFull   <= 1'b0;
      holdAddr   <= '0;
      holdData   <= '0;
      lastHost   <= 1'b0;
      rrLast     <= 1'b1;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      host_ready <= !holdFullNxt;
      holdFull   <= holdFullNxt;
      if (hostAccept) begin
        holdAddr <= host_addr;
        holdData <= host_data;
      end
      wr_strobe <= hostGrant || anyEnv;
      if (hostGrant) begin
        wr_addr  <= holdAddr;
        wr_data  <= holdData;
        lastHost <= 1'b1;
      end else if (anyEnv) begin
        wr_addr  <= envAddr[envPick];
        wr_data  <= envData[envPick];
        lastHost <= 1'b0;
        rrLast   <= envPick;
      end
    end
  end

endmodule
